// File: rtl/delivery_game_pkg.sv
// Shared constants, FSM encoding and LFSR step for the delivery-game map logic.
// Pure declarations: no latency, no state.
// Not applicable: no handshake lives in a package.
package delivery_game_pkg;

  localparam int          ROWS      = 128;
  localparam int          AW        = 7;
  localparam int          LANES     = 4;
  localparam int          OBST_GAP  = 8;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // One step of the 16-bit right-shifting Galois LFSR; a nonzero state never reaches zero
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/map_scroller_row_generator.sv
// Produces the next map row: empty except every OBST_GAP-th step, which is an LFSR obstacle row.
// Combinational row output; LFSR/gap counter advance on the cycle 'step' is high.
// No backpressure: caller pulses 'step' only when the row is consumed. SAFE_LANE_EN keeps a path open.
module row_generator
  import delivery_game_pkg::*;
#(
  parameter int          LANES    = delivery_game_pkg::LANES,
  parameter int          OBST_GAP = delivery_game_pkg::OBST_GAP,
  parameter logic [15:0] SEED     = delivery_game_pkg::LFSR_SEED
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             init,
  input  logic             step,
  output logic [LANES-1:0] row
);

  localparam int GW = (OBST_GAP > 1) ? $clog2(OBST_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(OBST_GAP - 1);

  logic [15:0]      lfsr_q, lfsr_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             obst;
  int               force_idx;
  logic [LANES-1:0] raw_row;
  logic [LANES-1:0] gen_row;

  // Raw obstacle candidate: LFSR low bits, with one pseudo-random lane reopened if fully blocked
  always_comb begin
    obst      = (gap_cnt_q == GAP_LAST);
    force_idx = int'(lfsr_q[10:8]) % LANES;
    raw_row   = lfsr_q[LANES-1:0];
    if (&raw_row) begin
      for (int i = 0; i < LANES; i++) begin
        if (i == force_idx) raw_row[i] = 1'b0;
      end
    end
  end

`ifdef SAFE_LANE_EN
  logic [LANES-1:0] free_mask_q, free_mask_d;
  logic [LANES-1:0] keep_free;

  // Reopen the lowest lane that was free in the previous obstacle row so a path always continues
  always_comb begin
    keep_free   = free_mask_q & (~free_mask_q + LANES'(1));
    gen_row     = obst ? (raw_row & ~keep_free) : '0;
    free_mask_d = free_mask_q;
    if (init)             free_mask_d = '1;
    else if (step && obst) free_mask_d = ~gen_row;
  end

  // Free-lane mask of the most recent obstacle row
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) free_mask_q <= '1;
    else        free_mask_q <= free_mask_d;
  end
`else
  // Without the safe-lane mask only the never-all-blocked rule shapes the row
  always_comb begin
    gen_row = obst ? raw_row : '0;
  end
`endif

  // Advance the LFSR and the obstacle spacing counter once per accepted step
  always_comb begin
    lfsr_d    = lfsr_q;
    gap_cnt_d = gap_cnt_q;
    if (init) begin
      lfsr_d    = SEED;
      gap_cnt_d = '0;
    end else if (step) begin
      lfsr_d    = lfsr_next(lfsr_q);
      gap_cnt_d = obst ? '0 : gap_cnt_q + GW'(1);
    end
  end

  // Generator state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q    <= SEED;
      gap_cnt_q <= '0;
    end else begin
      lfsr_q    <= lfsr_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign row = gen_row;

endmodule

// File: rtl/map_scroller.sv
// Scrolling ring-buffer delivery map: clears on reset/clear, then shifts one row per move pulse.
// rd_data and exit_row/exit_valid are registered (latency 1); ready rises after a ROWS-cycle clear.
// No backpressure: moves outside RUN are dropped. Optional feature macro: SAFE_LANE_EN.
module map_scroller
  import delivery_game_pkg::*;
#(
  parameter int          ROWS     = delivery_game_pkg::ROWS,
  parameter int          AW       = delivery_game_pkg::AW,
  parameter int          LANES    = delivery_game_pkg::LANES,
  parameter int          OBST_GAP = delivery_game_pkg::OBST_GAP,
  parameter logic [15:0] SEED     = delivery_game_pkg::LFSR_SEED
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             move_map,
  input  logic [AW-1:0]    rd_addr,
  output logic [LANES-1:0] rd_data,
  output logic [AW-1:0]    offset,
  output logic             ready,
  output logic             exit_valid,
  output logic [LANES-1:0] exit_row,
  output logic [15:0]      distance
);

  state_t           state_q, state_d;
  logic [AW-1:0]    clr_idx_q, clr_idx_d;
  logic [AW-1:0]    offset_q, offset_d;
  logic [15:0]      distance_q, distance_d;
  logic             exit_valid_q, exit_valid_d;
  logic [LANES-1:0] exit_row_q, exit_row_d;
  logic [LANES-1:0] rd_data_q, rd_data_d;
  logic [LANES-1:0] mem_q [ROWS];

  logic             move_acc, clr_we, mem_we;
  logic [AW-1:0]    new_phys, rd_phys, mem_waddr;
  logic [LANES-1:0] mem_wdata, gen_row;

  row_generator #(
    .LANES    (LANES),
    .OBST_GAP (OBST_GAP),
    .SEED     (SEED)
  ) u_row_gen (
    .clock (clock),
    .reset (reset),
    .init  (clear),
    .step  (move_acc),
    .row   (gen_row)
  );

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  // FSM next state: clear wins everywhere, CLEAR exits once the last row is wiped
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = CLEAR;
    end else begin
      case (state_q)
        CLEAR:   if (clr_idx_q == AW'(ROWS - 1)) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = CLEAR;
      endcase
    end
  end

  // FSM outputs: ready in RUN, wipe writes in CLEAR, moves only accepted in RUN without clear
  always_comb begin
    ready    = (state_q == RUN);
    clr_we   = (state_q == CLEAR);
    move_acc = (state_q == RUN) && move_map && !clear;
  end

  // Datapath next values; all reads see pre-move offset and pre-write memory
  always_comb begin
    new_phys     = offset_q - AW'(1);
    rd_phys      = offset_q + rd_addr;
    clr_idx_d    = clr_idx_q;
    offset_d     = offset_q;
    distance_d   = distance_q;
    exit_valid_d = 1'b0;
    exit_row_d   = exit_row_q;
    rd_data_d    = '0;
    if (clear) begin
      clr_idx_d  = '0;
      offset_d   = '0;
      distance_d = '0;
      exit_row_d = '0;
    end else begin
      if (state_q == CLEAR) clr_idx_d = clr_idx_q + AW'(1);
      if (state_q == RUN)   rd_data_d = mem_q[rd_phys];
      if (move_acc) begin
        offset_d     = new_phys;
        exit_row_d   = mem_q[new_phys];
        exit_valid_d = 1'b1;
        if (distance_q != 16'hFFFF) distance_d = distance_q + 16'd1;
      end
    end
  end

  // Single memory write port shared by the wipe sweep and the new top row
  always_comb begin
    mem_we    = clr_we || move_acc;
    mem_waddr = clr_we ? clr_idx_q : new_phys;
    mem_wdata = clr_we ? '0 : gen_row;
  end

  // Map storage; contents are defined by the CLEAR sweep, so no reset is needed
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clr_idx_q    <= '0;
      offset_q     <= '0;
      distance_q   <= '0;
      exit_valid_q <= 1'b0;
      exit_row_q   <= '0;
      rd_data_q    <= '0;
    end else begin
      clr_idx_q    <= clr_idx_d;
      offset_q     <= offset_d;
      distance_q   <= distance_d;
      exit_valid_q <= exit_valid_d;
      exit_row_q   <= exit_row_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign offset     = offset_q;
  assign exit_valid = exit_valid_q;
  assign exit_row   = exit_row_q;
  assign distance   = distance_q;

endmodule
